// File: rtl/pe_pkg.sv
// Shared definitions for the butterfly processing element.
// Holds the per-sample mode encodings and the modular add/sub/halve helpers.
// Helpers operate on MAX_W-bit containers and take the modulus as an argument,
// so callers with any DATA_WIDTH below MAX_W cast in and truncate out.
package pe_pkg;

    localparam logic [1:0] MODE_CT   = 2'b00;
    localparam logic [1:0] MODE_GS   = 2'b01;
    localparam logic [1:0] MODE_DUAL = 2'b10;

    localparam int unsigned MAX_W = 32;

    // (a + b) mod q for a, b < q; one extra bit holds the carry.
    function automatic logic [MAX_W-1:0] modadd(input logic [MAX_W-1:0] a,
                                                input logic [MAX_W-1:0] b,
                                                input logic [MAX_W-1:0] q);
        logic [MAX_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, q}) begin
            s = s - {1'b0, q};
        end
        return s[MAX_W-1:0];
    endfunction

    // (a - b) mod q for a, b < q.
    function automatic logic [MAX_W-1:0] modsub(input logic [MAX_W-1:0] a,
                                                input logic [MAX_W-1:0] b,
                                                input logic [MAX_W-1:0] q);
        logic [MAX_W-1:0] d;
        if (a >= b) begin
            d = a - b;
        end else begin
            d = a + q - b;
        end
        return d;
    endfunction

    // x * 2^-1 mod q for odd q: odd x is made even by adding q first.
    function automatic logic [MAX_W-1:0] half(input logic [MAX_W-1:0] x,
                                              input logic [MAX_W-1:0] q);
        logic [MAX_W:0] s;
        if (x[0]) begin
            s = {1'b0, x} + {1'b0, q};
        end else begin
            s = {1'b0, x};
        end
        return s[MAX_W:1];
    endfunction

endpackage

// File: rtl/pe_modmul.sv
// Pipelined exact modular multiplier: p = (a * b) mod Q.
// Ports: clk, rst (async active-high), ce (stage enable), a/b operands (< Q),
// p result. The full 2*DATA_WIDTH product is registered and delayed through
// MUL_LAT stages; the reduction is applied to the last stage, so p is valid
// MUL_LAT enabled cycles after a/b are presented.
module pe_modmul #(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned Q          = 3329,
    parameter int unsigned MUL_LAT    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] p
);

    localparam int unsigned PW = 2 * DATA_WIDTH;

    logic [PW-1:0] prod_d [MUL_LAT];
    logic [PW-1:0] prod_q [MUL_LAT];

    always_comb begin
        prod_d[0] = PW'(a) * PW'(b);
        for (int i = 1; i < int'(MUL_LAT); i++) begin
            prod_d[i] = prod_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(MUL_LAT); i++) begin
                prod_q[i] <= '0;
            end
        end else if (ce) begin
            for (int i = 0; i < int'(MUL_LAT); i++) begin
                prod_q[i] <= prod_d[i];
            end
        end
    end

    assign p = DATA_WIDTH'(prod_q[MUL_LAT-1] % PW'(Q));

endmodule

// File: rtl/pe2_bf_pipe.sv
// Fully pipelined NTT butterfly element (CT / GS / dual-product per sample).
// Ports: clk, rst (async active-high), ce (global stage enable), in_valid,
// mode (00 CT, 01 GS, 10 DUAL, 11 -> CT), operands u, v, w1, w2 (all < Q);
// out_valid, bf_upper, bf_lower after MUL_LAT+2 enabled cycles in every mode.
// Optional macro PE2_BF_HALF_EN: GS results are multiplied by 2^-1 mod Q.
module pe2_bf_pipe
    import pe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned Q          = 3329,
    parameter int unsigned MUL_LAT    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] u,
    input  logic [DATA_WIDTH-1:0] v,
    input  logic [DATA_WIDTH-1:0] w1,
    input  logic [DATA_WIDTH-1:0] w2,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] bf_upper,
    output logic [DATA_WIDTH-1:0] bf_lower
);

    localparam logic [MAX_W-1:0] QW = MAX_W'(Q);

    // S0 input register
    logic [DATA_WIDTH-1:0] u_d, u_q, v_d, v_q, w1_d, w1_q, w2_d, w2_q;
    logic [1:0]            mode_d, mode_q;
    logic                  vld_d, vld_q;

    // Side path matching the multiplier depth: carries the non-multiplied
    // operand (u for CT, u+v for GS), the mode and the valid bit.
    logic [DATA_WIDTH-1:0] dly_d [MUL_LAT];
    logic [DATA_WIDTH-1:0] dly_q [MUL_LAT];
    logic [1:0]            dmode_d [MUL_LAT];
    logic [1:0]            dmode_q [MUL_LAT];
    logic                  dvld_d [MUL_LAT];
    logic                  dvld_q [MUL_LAT];

    logic [DATA_WIDTH-1:0] mul1_a, p1, p2;

    // Output register
    logic [DATA_WIDTH-1:0] upper_d, upper_q, lower_d, lower_q;
    logic                  ovld_d, ovld_q;

    always_comb begin
        u_d    = u;
        v_d    = v;
        w1_d   = w1;
        w2_d   = w2;
        vld_d  = in_valid;
        // Reserved encoding is folded into CT so later stages see three modes.
        mode_d = (mode == MODE_GS || mode == MODE_DUAL) ? mode : MODE_CT;
    end

    // S0 output: select multiplier-1 operand and the side-path value.
    always_comb begin
        unique case (mode_q)
            MODE_GS:   mul1_a = DATA_WIDTH'(modsub(MAX_W'(u_q), MAX_W'(v_q), QW));
            MODE_DUAL: mul1_a = u_q;
            default:   mul1_a = v_q;
        endcase
        if (mode_q == MODE_GS) begin
            dly_d[0] = DATA_WIDTH'(modadd(MAX_W'(u_q), MAX_W'(v_q), QW));
        end else begin
            dly_d[0] = u_q;
        end
        dmode_d[0] = mode_q;
        dvld_d[0]  = vld_q;
        for (int i = 1; i < int'(MUL_LAT); i++) begin
            dly_d[i]   = dly_q[i-1];
            dmode_d[i] = dmode_q[i-1];
            dvld_d[i]  = dvld_q[i-1];
        end
    end

    pe_modmul #(
        .DATA_WIDTH (DATA_WIDTH),
        .Q          (Q),
        .MUL_LAT    (MUL_LAT)
    ) u_mul1 (
        .clk (clk),
        .rst (rst),
        .ce  (ce),
        .a   (mul1_a),
        .b   (w1_q),
        .p   (p1)
    );

    pe_modmul #(
        .DATA_WIDTH (DATA_WIDTH),
        .Q          (Q),
        .MUL_LAT    (MUL_LAT)
    ) u_mul2 (
        .clk (clk),
        .rst (rst),
        .ce  (ce),
        .a   (v_q),
        .b   (w2_q),
        .p   (p2)
    );

    // Final combine at the tail of the multiplier pipeline.
    always_comb begin
        logic [DATA_WIDTH-1:0] d;
        d      = dly_q[MUL_LAT-1];
        ovld_d = dvld_q[MUL_LAT-1];
        unique case (dmode_q[MUL_LAT-1])
            MODE_GS: begin
`ifdef PE2_BF_HALF_EN
                upper_d = DATA_WIDTH'(half(MAX_W'(d), QW));
                lower_d = DATA_WIDTH'(half(MAX_W'(p1), QW));
`else
                upper_d = d;
                lower_d = p1;
`endif
            end
            MODE_DUAL: begin
                upper_d = DATA_WIDTH'(modsub(MAX_W'(p1), MAX_W'(p2), QW));
                lower_d = DATA_WIDTH'(modadd(MAX_W'(p1), MAX_W'(p2), QW));
            end
            default: begin
                upper_d = DATA_WIDTH'(modadd(MAX_W'(d), MAX_W'(p1), QW));
                lower_d = DATA_WIDTH'(modsub(MAX_W'(d), MAX_W'(p1), QW));
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            u_q     <= '0;
            v_q     <= '0;
            w1_q    <= '0;
            w2_q    <= '0;
            mode_q  <= '0;
            vld_q   <= 1'b0;
            for (int i = 0; i < int'(MUL_LAT); i++) begin
                dly_q[i]   <= '0;
                dmode_q[i] <= '0;
                dvld_q[i]  <= 1'b0;
            end
            upper_q <= '0;
            lower_q <= '0;
            ovld_q  <= 1'b0;
        end else if (ce) begin
            u_q     <= u_d;
            v_q     <= v_d;
            w1_q    <= w1_d;
            w2_q    <= w2_d;
            mode_q  <= mode_d;
            vld_q   <= vld_d;
            for (int i = 0; i < int'(MUL_LAT); i++) begin
                dly_q[i]   <= dly_d[i];
                dmode_q[i] <= dmode_d[i];
                dvld_q[i]  <= dvld_d[i];
            end
            upper_q <= upper_d;
            lower_q <= lower_d;
            ovld_q  <= ovld_d;
        end
    end

    assign out_valid = ovld_q;
    assign bf_upper  = upper_q;
    assign bf_lower  = lower_q;

endmodule

// File: tb/tb_pe2_bf_pipe.sv
// Self-checking bench for pe2_bf_pipe with default parameters (LAT = 4).
module tb_pe2_bf_pipe;

    localparam int DW  = 12;
    localparam int QM  = 3329;
    localparam int LAT = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ce = 1'b1;
    logic          in_valid = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [DW-1:0] u = '0, v = '0, w1 = '0, w2 = '0;
    logic          out_valid;
    logic [DW-1:0] bf_upper, bf_lower;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pe2_bf_pipe #(
        .DATA_WIDTH (DW),
        .Q          (QM),
        .MUL_LAT    (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .in_valid  (in_valid),
        .mode      (mode),
        .u         (u),
        .v         (v),
        .w1        (w1),
        .w2        (w2),
        .out_valid (out_valid),
        .bf_upper  (bf_upper),
        .bf_lower  (bf_lower)
    );

    // Advance one clock edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [1:0] m, input int a, input int b,
                         input int c, input int d);
        in_valid = vld;
        mode     = m;
        u        = DW'(a);
        v        = DW'(b);
        w1       = DW'(c);
        w2       = DW'(d);
    endtask

    // Reference model
    function automatic int r_add(input int a, input int b);
        return (a + b) % QM;
    endfunction
    function automatic int r_sub(input int a, input int b);
        return (a - b + QM) % QM;
    endfunction
    function automatic int r_mul(input int a, input int b);
        return int'((longint'(a) * longint'(b)) % QM);
    endfunction
    function automatic int r_half(input int x);
        return (x % 2 == 1) ? (x + QM) / 2 : x / 2;
    endfunction
    // Returns {upper, lower} packed as upper*65536 + lower.
    function automatic int r_bf(input int m, input int a, input int b, input int c, input int d);
        int t, up, lo;
        if (m == 1) begin
            up = r_add(a, b);
            lo = r_mul(r_sub(a, b), c);
`ifdef PE2_BF_HALF_EN
            up = r_half(up);
            lo = r_half(lo);
`endif
        end else if (m == 2) begin
            up = r_sub(r_mul(a, c), r_mul(b, d));
            lo = r_add(r_mul(a, c), r_mul(b, d));
        end else begin
            t  = r_mul(b, c);
            up = r_add(a, t);
            lo = r_sub(a, t);
        end
        return up * 65536 + lo;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 2'b00, 0, 0, 0, 0);
        repeat (2) tick();
        checks++;
        if (out_valid !== 1'b0 || bf_upper !== '0 || bf_lower !== '0) begin
            failures++;
            $display("FAIL reset_state: got vld=%0b up=%0d lo=%0d, want 0 0 0",
                     out_valid, bf_upper, bf_lower);
        end
        rst = 1'b0;
        tick();
        // Get a valid result onto the outputs, then reset with another in flight.
        drive(1'b1, 2'b00, 10, 2, 3, 0);
        tick();
        drive(1'b0, 2'b00, 0, 0, 0, 0);
        repeat (LAT - 1) tick();
        checks++;
        if (out_valid !== 1'b1 || bf_upper !== 12'd16) begin
            failures++;
            $display("FAIL reset_pre: got vld=%0b up=%0d, want 1 16", out_valid, bf_upper);
        end
        drive(1'b1, 2'b00, 100, 7, 9, 0);
        tick();
        drive(1'b0, 2'b00, 0, 0, 0, 0);
        tick();
        #3 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || bf_upper !== '0 || bf_lower !== '0) begin
            failures++;
            $display("FAIL reset_async: got vld=%0b up=%0d lo=%0d, want 0 0 0",
                     out_valid, bf_upper, bf_lower);
        end
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_flush cycle %0d: got vld=%0b, want 0", i, out_valid);
            end
        end
    endtask

    // One sample, checked exactly LAT edges later.
    task automatic test_single(input string name, input logic [1:0] m, input int a, input int b,
                               input int c, input int d, input int exp_up, input int exp_lo);
        drive(1'b1, m, a, b, c, d);
        tick();
        drive(1'b0, 2'b00, 0, 0, 0, 0);
        for (int i = 1; i < LAT; i++) begin
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL %s early_valid at %0d: got 1, want 0", name, i);
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b1 || bf_upper !== DW'(exp_up) || bf_lower !== DW'(exp_lo)) begin
            failures++;
            $display("FAIL %s: got vld=%0b up=%0d lo=%0d, want 1 %0d %0d",
                     name, out_valid, bf_upper, bf_lower, exp_up, exp_lo);
        end
        tick();
    endtask

    task automatic test_ct();
        test_single("ct_basic", 2'b00, 10, 2, 3, 0, 16, 4);
        test_single("ct_wrap", 2'b00, 3328, 1, 5, 0, 4, 3323);
        test_single("ct_reserved_mode", 2'b11, 10, 2, 3, 0, 16, 4);
    endtask

    task automatic test_gs();
`ifdef PE2_BF_HALF_EN
        test_single("gs_half", 2'b01, 1, 3, 2, 0, 2, 3327);
`else
        test_single("gs_basic", 2'b01, 1, 3, 2, 0, 4, 3325);
`endif
    endtask

    task automatic test_dual();
        test_single("dual_basic", 2'b10, 2, 4, 3, 5, 3315, 26);
    endtask

    // Four CT samples; ce low on edges 6..8 while results are emerging.
    task automatic test_stall();
        int su [4] = '{10, 3328, 100, 5};
        int sv [4] = '{2, 1, 7, 20};
        int sw [4] = '{3, 5, 9, 100};
        int eu [4] = '{16, 4, 163, 2005};
        int el [4] = '{4, 3323, 37, 1334};
        int ev, ei;
        for (int e = 1; e <= 11; e++) begin
            if (e <= 4) drive(1'b1, 2'b00, su[e-1], sv[e-1], sw[e-1], 0);
            else        drive(1'b1, 2'b00, 1, 1, 1, 0);  // ignored while ce=0 / must not leak
            if (e >= 9) in_valid = 1'b0;
            if (e == 5) in_valid = 1'b0;
            ce = (e >= 6 && e <= 8) ? 1'b0 : 1'b1;
            tick();
            ev = 1;
            ei = 0;
            if (e < 4 || e == 11) ev = 0;
            else if (e == 4) ei = 0;
            else if (e <= 8) ei = 1;
            else ei = e - 7;
            checks++;
            if (out_valid !== ev[0] ||
                (ev == 1 && (bf_upper !== DW'(eu[ei]) || bf_lower !== DW'(el[ei])))) begin
                failures++;
                $display("FAIL stall edge %0d: got vld=%0b up=%0d lo=%0d, want %0d %0d %0d",
                         e, out_valid, bf_upper, bf_lower, ev, eu[ei], el[ei]);
            end
        end
        ce = 1'b1;
        drive(1'b0, 2'b00, 0, 0, 0, 0);
        repeat (2) tick();
    endtask

    task automatic test_back_to_back();
        logic [1:0] sm [4] = '{2'b00, 2'b01, 2'b10, 2'b00};
        int sa [4] = '{10, 1, 2, 3328};
        int sb [4] = '{2, 3, 4, 1};
        int sc [4] = '{3, 2, 3, 5};
        int sd [4] = '{0, 0, 5, 0};
`ifdef PE2_BF_HALF_EN
        int eu [4] = '{16, 2, 3315, 4};
        int el [4] = '{4, 3327, 26, 3323};
`else
        int eu [4] = '{16, 4, 3315, 4};
        int el [4] = '{4, 3325, 26, 3323};
`endif
        for (int e = 1; e <= 8; e++) begin
            if (e <= 4) drive(1'b1, sm[e-1], sa[e-1], sb[e-1], sc[e-1], sd[e-1]);
            else        drive(1'b0, 2'b00, 0, 0, 0, 0);
            tick();
            if (e >= 4 && e <= 7) begin
                checks++;
                if (out_valid !== 1'b1 || bf_upper !== DW'(eu[e-4]) ||
                    bf_lower !== DW'(el[e-4])) begin
                    failures++;
                    $display("FAIL interleave %0d: got vld=%0b up=%0d lo=%0d, want 1 %0d %0d",
                             e - 4, out_valid, bf_upper, bf_lower, eu[e-4], el[e-4]);
                end
            end else if (e == 8) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL interleave_tail: got vld=1, want 0");
                end
            end
        end
    endtask

    task automatic test_random();
        int q[$];
        int a, b, c, d, m, exp;
        logic ce_now;
        for (int n = 0; n < 10000 + LAT + 2; n++) begin
            a = $urandom_range(0, QM - 1);
            b = $urandom_range(0, QM - 1);
            c = $urandom_range(0, QM - 1);
            d = $urandom_range(0, QM - 1);
            m = $urandom_range(0, 3);
            if (n < 10000) begin
                drive(1'($urandom_range(0, 1)), 2'(m), a, b, c, d);
                ce = ($urandom_range(0, 3) != 0);
            end else begin
                drive(1'b0, 2'(m), a, b, c, d);
                ce = 1'b1;
            end
            ce_now = ce;
            if (ce_now && in_valid) q.push_back(r_bf(m, a, b, c, d));
            tick();
            if (ce_now && out_valid) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL random_extra at %0d: got up=%0d lo=%0d, want none",
                             n, bf_upper, bf_lower);
                end else begin
                    exp = q.pop_front();
                    if (bf_upper !== DW'(exp / 65536) || bf_lower !== DW'(exp % 65536)) begin
                        failures++;
                        $display("FAIL random at %0d: got up=%0d lo=%0d, want %0d %0d",
                                 n, bf_upper, bf_lower, exp / 65536, exp % 65536);
                    end
                end
            end
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL random_lost: got %0d pending, want 0", q.size());
        end
        ce = 1'b1;
    endtask

    initial begin
        test_reset();
        test_ct();
        test_gs();
        test_dual();
        test_stall();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pe2_bf_pipe.md
Name: pe2_bf_pipe

Overview:
- Parametrised, fully pipelined butterfly processing element. Successor to the fixed 12-bit dual-multiply PE.
- Supports three per-sample modes:
  - Cooley-Tukey (forward NTT)
  - Gentleman-Sande (inverse NTT)
  - dual-product (pointwise / merged-twiddle)
- Adds a valid pipeline, a clock-enable stall and a fixed mode-independent latency.
- Sits between the coefficient-memory read mux and the write-back path of the NTT core; accepts one butterfly per enabled cycle.

Parameters:
- DATA_WIDTH, 12, coefficient width in bits; must satisfy Q < 2^DATA_WIDTH.
- Q, 3329, prime modulus.
- MUL_LAT, 2, pipeline depth of each modular multiplier (>=1).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- ce  input  1  pipeline clock enable; 0 freezes every stage
- in_valid  input  1  input operands valid this cycle
- mode  input  2  00 CT, 01 GS, 10 DUAL, 11 reserved (treated as CT)
- u  input  DATA_WIDTH  upper operand, < Q
- v  input  DATA_WIDTH  lower operand, < Q
- w1  input  DATA_WIDTH  twiddle 1, < Q
- w2  input  DATA_WIDTH  twiddle 2 (DUAL only), < Q
- out_valid  output  1  bf_upper/bf_lower valid
- bf_upper  output  DATA_WIDTH  upper result
- bf_lower  output  DATA_WIDTH  lower result

Behaviour:
- Reset: asynchronous, active-high, on rst. All pipeline registers, valid bits and stored modes clear to 0. out_valid=0, bf_upper=0, bf_lower=0. Asserting rst mid-stream discards all in-flight samples; no partial output follows deassertion.
- Stages, each advancing only when ce=1:
  - S0: input register (u, v, w1, w2, mode, in_valid).
  - S1..S_MUL_LAT: multiplier pipeline.
  - Final: output register.
- Latency LAT = MUL_LAT+2 enabled cycles, identical for every mode. Non-multiplied operands travel through matching delay registers. Mode travels with its sample, so back-to-back samples of different modes need no bubble.
- ce=0: every register holds, including out_valid and outputs. in_valid is ignored while ce=0.
- Arithmetic (all results in [0, Q-1]):
  - modadd(a,b) = a+b, minus Q if >= Q; computed in DATA_WIDTH+1 bits.
  - modsub(a,b) = a-b, plus Q if negative.
  - modmul(a,b) = (a*b) mod Q, full 2*DATA_WIDTH product, exact reduction.
- CT: t = modmul(v,w1); bf_upper = modadd(u,t); bf_lower = modsub(u,t).
- GS: bf_upper = modadd(u,v), delayed to align; bf_lower = modmul(modsub(u,v), w1). The subtraction is computed in S0 output before the multiplier.
- DUAL: p1 = modmul(u,w1), p2 = modmul(v,w2); bf_lower = modadd(p1,p2); bf_upper = modsub(p1,p2).
- Data outputs update whenever the final stage is enabled, regardless of valid. Consumers qualify with out_valid; when out_valid=0 the output values are don't-care.
- Operands >= Q: results undefined. The bench must not drive them.

Optional Feature:
- Macro: PE2_BF_HALF_EN.
- Defined: in GS mode both results are multiplied by 2^-1 mod Q before the output register.
  - x even: x/2.
  - x odd: (x+Q)/2, computed in DATA_WIDTH+1 bits.
  - Latency unchanged; CT and DUAL unaffected.
- Undefined: no halving logic; GS outputs exactly as above.

Decomposition:
- Shared package pe_pkg holds:
  - mode encodings MODE_CT=2'b00, MODE_GS=2'b01, MODE_DUAL=2'b10;
  - modadd/modsub/half functions parametrised on width and Q.
- One sub-module: pe_modmul (DATA_WIDTH, Q, MUL_LAT). Pipelined exact modular multiply with ce, asynchronous active-high rst. Instantiated twice.

Test Plan:
All cases use defaults Q=3329, MUL_LAT=2, LAT=4, with ce=1 unless stated.
1. Reset / idle:
   - rst pulse asynchronous to clk -> outputs and out_valid 0 immediately.
   - Sample in flight at reset -> never emerges.
2. CT:
   - u=10, v=2, w1=3 -> out_valid 4 cycles later; bf_upper=16, bf_lower=4.
   - Wrap case u=3328, v=1, w1=5 -> bf_upper=4, bf_lower=3323.
3. GS:
   - u=1, v=3, w1=2 -> bf_upper=4, bf_lower=3325.
   - With PE2_BF_HALF_EN -> bf_upper=2, bf_lower=3327.
4. DUAL:
   - u=2, w1=3, v=4, w2=5 -> bf_lower=26, bf_upper=3315.
5. Stall:
   - Stream 4 CT samples, drop ce for 3 cycles mid-stream -> outputs and out_valid frozen during stall.
   - Results appear in order, none lost or duplicated; total cycles = 4+LAT-1+3.
6. Mode interleave:
   - Back-to-back CT, GS, DUAL, CT samples from cases 2-4 -> four consecutive valid outputs, each matching its own mode's expected values.
   - Compare against a randomized reference-model scoreboard over 10k samples.
